// File: rtl/game_sequencer.sv
// game_sequencer
// Central controller for the Mastermind-style game datapath. It keeps the
// game-credit count, sequences the four master-pattern writes, counts guess
// rounds, hands each guess to the checker over a req/ack handshake, and
// decides win/loss.
//
// Ports:
//   clock          system clock, all state on the rising edge
//   reset          asynchronous active-low clear
//   creditAdd      one-cycle pulse from the coin acceptor (+1 credit)
//   StartGame      button level; rising edge starts a game
//   LoadShapeNow   button level; rising edge loads LoadShape at ShapeLocation
//   GradeIt        button level; rising edge submits the current guess
//   LoadShape      shape code to load (valid 3'b001..3'b110)
//   ShapeLocation  master location to load
//   gradeAck       checker done; znarlyIn valid while high
//   znarlyIn       exact-match count from the checker (0..4)
//   masterWe       one-cycle write strobe to the master register
//   masterAddr     write location, valid with masterWe
//   masterShape    write data, valid with masterWe
//   gradeReq       grade request, held until gradeAck is sampled
//   loadingShape   high while loading the master pattern
//   ongoingGame    high while a game is in progress
//   NumGames       credits remaining
//   RoundNumber    rounds used in the current game
//   GameWon        high from a win until the next game start
module game_sequencer #(
  parameter int MAX_ROUNDS = 8,
  parameter int MAX_GAMES  = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       creditAdd,
  input  logic       StartGame,
  input  logic       LoadShapeNow,
  input  logic       GradeIt,
  input  logic [2:0] LoadShape,
  input  logic [1:0] ShapeLocation,
  input  logic       gradeAck,
  input  logic [3:0] znarlyIn,
  output logic       masterWe,
  output logic [1:0] masterAddr,
  output logic [2:0] masterShape,
  output logic       gradeReq,
  output logic       loadingShape,
  output logic       ongoingGame,
  output logic [3:0] NumGames,
  output logic [3:0] RoundNumber,
  output logic       GameWon
);

  localparam logic [3:0] ROUND_LIMIT = 4'(MAX_ROUNDS);
  localparam logic [3:0] GAME_LIMIT  = 4'(MAX_GAMES);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GRADE, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] mask, mask_next;
  logic       start_prev, load_prev, grade_prev;
  logic       start_edge, load_edge, grade_edge;
  logic       start_ok, shape_valid;

  logic       we_next;
  logic [1:0] addr_next;
  logic [2:0] shape_next;
  logic       req_next;
  logic       loading_next;
  logic       ongoing_next;
  logic [3:0] games_next;
  logic [3:0] round_next;
  logic       won_next;

  assign start_edge  = StartGame & ~start_prev;
  assign load_edge   = LoadShapeNow & ~load_prev;
  assign grade_edge  = GradeIt & ~grade_prev;
  assign shape_valid = (LoadShape != 3'b000) && (LoadShape != 3'b111);
  // Eligibility looks at the registered credit count only, so a coin arriving
  // in the same cycle cannot enable a start from zero.
  assign start_ok    = start_edge && (NumGames != 4'd0) &&
                       ((state == IDLE) || (state == DONE));

  always_comb begin
    state_next = state;
    mask_next  = mask;
    we_next    = 1'b0;
    addr_next  = masterAddr;
    shape_next = masterShape;
    req_next   = gradeReq;
    round_next = RoundNumber;
    won_next   = GameWon;

    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_next = LOAD;
          round_next = 4'd0;
          won_next   = 1'b0;
          mask_next  = 4'b0000;
        end
      end
      LOAD: begin
        // The 4th write leaves the mask full; leave LOAD one edge later,
        // while that write strobe is on the bus.
        if (mask == 4'b1111) begin
          state_next = PLAY;
        end else if (load_edge && shape_valid) begin
          we_next    = 1'b1;
          addr_next  = ShapeLocation;
          shape_next = LoadShape;
          mask_next  = mask | (4'b0001 << ShapeLocation);
        end
      end
      PLAY: begin
        if (grade_edge) begin
          state_next = GRADE;
          round_next = RoundNumber + 4'd1;
          req_next   = 1'b1;
        end
      end
      GRADE: begin
        if (gradeAck) begin
          req_next = 1'b0;
          if (znarlyIn == 4'd4) begin
            state_next = DONE;
            won_next   = 1'b1;
          end else if (RoundNumber == ROUND_LIMIT) begin
            state_next = DONE;
          end else begin
            state_next = PLAY;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Start and coin together cancel out.
    case ({start_ok, creditAdd})
      2'b10:   games_next = NumGames - 4'd1;
      2'b01:   games_next = (NumGames < GAME_LIMIT) ? NumGames + 4'd1 : NumGames;
      default: games_next = NumGames;
    endcase

    loading_next = (state_next == LOAD);
    ongoing_next = (state_next == LOAD) || (state_next == PLAY) ||
                   (state_next == GRADE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mask         <= 4'b0000;
      // Prev flops reset high so a button held through reset gives no edge.
      start_prev   <= 1'b1;
      load_prev    <= 1'b1;
      grade_prev   <= 1'b1;
      masterWe     <= 1'b0;
      masterAddr   <= 2'd0;
      masterShape  <= 3'd0;
      gradeReq     <= 1'b0;
      loadingShape <= 1'b0;
      ongoingGame  <= 1'b0;
      NumGames     <= 4'd0;
      RoundNumber  <= 4'd0;
      GameWon      <= 1'b0;
    end else begin
      state        <= state_next;
      mask         <= mask_next;
      start_prev   <= StartGame;
      load_prev    <= LoadShapeNow;
      grade_prev   <= GradeIt;
      masterWe     <= we_next;
      masterAddr   <= addr_next;
      masterShape  <= shape_next;
      gradeReq     <= req_next;
      loadingShape <= loading_next;
      ongoingGame  <= ongoing_next;
      NumGames     <= games_next;
      RoundNumber  <= round_next;
      GameWon      <= won_next;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed stimulus, a game-level reference
// model compared every cycle, plus literal expectations per scenario.
module tb_game_sequencer;

  localparam int MAX_R = 8;
  localparam int MAX_G = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       creditAdd = 1'b0;
  logic       StartGame = 1'b0;
  logic       LoadShapeNow = 1'b0;
  logic       GradeIt = 1'b0;
  logic [2:0] LoadShape = 3'd0;
  logic [1:0] ShapeLocation = 2'd0;
  logic       gradeAck = 1'b0;
  logic [3:0] znarlyIn = 4'd0;
  logic       masterWe;
  logic [1:0] masterAddr;
  logic [2:0] masterShape;
  logic       gradeReq;
  logic       loadingShape;
  logic       ongoingGame;
  logic [3:0] NumGames;
  logic [3:0] RoundNumber;
  logic       GameWon;

  game_sequencer #(.MAX_ROUNDS(MAX_R), .MAX_GAMES(MAX_G)) dut (
    .clock(clock), .reset(reset), .creditAdd(creditAdd), .StartGame(StartGame),
    .LoadShapeNow(LoadShapeNow), .GradeIt(GradeIt), .LoadShape(LoadShape),
    .ShapeLocation(ShapeLocation), .gradeAck(gradeAck), .znarlyIn(znarlyIn),
    .masterWe(masterWe), .masterAddr(masterAddr), .masterShape(masterShape),
    .gradeReq(gradeReq), .loadingShape(loadingShape), .ongoingGame(ongoingGame),
    .NumGames(NumGames), .RoundNumber(RoundNumber), .GameWon(GameWon)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game-level reference model ----------------
  int m_credits = 0;
  int m_round   = 0;
  bit m_won = 0, m_in_game = 0, m_loading = 0, m_playing = 0, m_grading = 0;
  bit m_loaded[4] = '{0, 0, 0, 0};
  bit m_we = 0;
  int m_addr = 0, m_shape = 0;
  bit p_start = 1, p_load = 1, p_grade = 1;

  // Observed-activity counters used by the literal checks.
  int we_pulses = 0;
  int req_cycles = 0;
  int last_shape[4] = '{0, 0, 0, 0};

  task automatic model_reset();
    m_credits = 0; m_round = 0; m_won = 0;
    m_in_game = 0; m_loading = 0; m_playing = 0; m_grading = 0;
    for (int i = 0; i < 4; i++) m_loaded[i] = 0;
    m_we = 0; m_addr = 0; m_shape = 0;
    p_start = 1; p_load = 1; p_grade = 1;
  endtask

  task automatic model_step();
    bit se, le, ge, can_start;
    int n_loaded;
    se = StartGame && !p_start;
    le = LoadShapeNow && !p_load;
    ge = GradeIt && !p_grade;
    can_start = se && !m_in_game && (m_credits > 0);
    n_loaded = 0;
    for (int i = 0; i < 4; i++) n_loaded += int'(m_loaded[i]);
    m_we = 0;
    if (can_start) begin
      m_in_game = 1; m_loading = 1; m_round = 0; m_won = 0;
      for (int i = 0; i < 4; i++) m_loaded[i] = 0;
    end else if (m_loading) begin
      if (n_loaded == 4) begin
        m_loading = 0; m_playing = 1;
      end else if (le && LoadShape >= 1 && LoadShape <= 6) begin
        m_we = 1; m_addr = int'(ShapeLocation); m_shape = int'(LoadShape);
        m_loaded[ShapeLocation] = 1;
      end
    end else if (m_playing) begin
      if (ge) begin
        m_playing = 0; m_grading = 1; m_round++;
      end
    end else if (m_grading && gradeAck) begin
      m_grading = 0;
      if (znarlyIn == 4) begin
        m_won = 1; m_in_game = 0;
      end else if (m_round == MAX_R) begin
        m_in_game = 0;
      end else begin
        m_playing = 1;
      end
    end
    if (can_start && !creditAdd) m_credits--;
    else if (!can_start && creditAdd && m_credits < MAX_G) m_credits++;
    p_start = StartGame; p_load = LoadShapeNow; p_grade = GradeIt;
  endtask

  task automatic compare();
    check("NumGames", int'(NumGames), m_credits);
    check("RoundNumber", int'(RoundNumber), m_round);
    check("GameWon", int'(GameWon), int'(m_won));
    check("ongoingGame", int'(ongoingGame), int'(m_in_game));
    check("loadingShape", int'(loadingShape), int'(m_loading));
    check("gradeReq", int'(gradeReq), int'(m_grading));
    check("masterWe", int'(masterWe), int'(m_we));
    if (m_we) begin
      check("masterAddr", int'(masterAddr), m_addr);
      check("masterShape", int'(masterShape), m_shape);
    end
    if (masterWe) begin
      we_pulses++;
      last_shape[masterAddr] = int'(masterShape);
    end
    if (gradeReq) req_cycles++;
  endtask

  initial begin
    @(posedge clock);
    forever begin
      if (!reset) model_reset();
      else model_step();
      #2;
      compare();
      @(posedge clock or negedge reset);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input bit start, input bit credit);
    StartGame = start; creditAdd = credit;
    @(negedge clock);
    StartGame = 1'b0; creditAdd = 1'b0;
    @(negedge clock);
  endtask

  task automatic load(input int loc, input int shape);
    ShapeLocation = 2'(loc); LoadShape = 3'(shape); LoadShapeNow = 1'b1;
    @(negedge clock);
    LoadShapeNow = 1'b0;
    @(negedge clock);
  endtask

  task automatic grade(input int wait_cycles, input int z);
    GradeIt = 1'b1;
    @(negedge clock);
    GradeIt = 1'b0;
    repeat (wait_cycles) @(negedge clock);
    gradeAck = 1'b1; znarlyIn = 4'(z);
    @(negedge clock);
    gradeAck = 1'b0; znarlyIn = 4'd0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic load_all();
    for (int i = 0; i < 4; i++) load(i, i + 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // 1: reset state, credits, start
    tick(1);
    check("rst_NumGames", int'(NumGames), 0);
    check("rst_gradeReq", int'(gradeReq), 0);
    check("rst_ongoing", int'(ongoingGame), 0);
    reset = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
    check("t1_credits3", int'(NumGames), 3);
    check("t1_model_credits", m_credits, 3);
    press(1'b1, 1'b0);
    check("t1_credits2", int'(NumGames), 2);
    check("t1_loading", int'(loadingShape), 1);
    check("t1_ongoing", int'(ongoingGame), 1);
    check("t1_round", int'(RoundNumber), 0);

    // 2: pattern load with overwrite and an invalid code
    we_pulses = 0;
    load(0, 1); load(1, 2); load(1, 3); load(2, 7); load(2, 5);
    check("t2_still_loading", int'(loadingShape), 1);
    load(3, 4);
    check("t2_we_pulses", we_pulses, 5);
    check("t2_loc1_shape", last_shape[1], 3);
    check("t2_loc2_shape", last_shape[2], 5);
    check("t2_left_load", int'(loadingShape), 0);
    check("t2_ongoing", int'(ongoingGame), 1);

    // 3: handshake with delayed ack, then a win
    req_cycles = 0;
    grade(3, 2);
    check("t3_req_cycles", req_cycles, 4);
    check("t3_round", int'(RoundNumber), 1);
    check("t3_back_to_play", int'(ongoingGame), 1);
    grade(0, 4);
    check("t3_won", int'(GameWon), 1);
    check("t3_ongoing", int'(ongoingGame), 0);

    // 4: loss after MAX_ROUNDS rounds
    press(1'b1, 1'b0);
    check("t4_won_cleared", int'(GameWon), 0);
    check("t4_credits", int'(NumGames), 1);
    load_all();
    for (int r = 0; r < MAX_R; r++) grade(1, 1);
    check("t4_round", int'(RoundNumber), 8);
    check("t4_model_round", m_round, 8);
    check("t4_lost", int'(GameWon), 0);
    check("t4_ongoing", int'(ongoingGame), 0);
    req_cycles = 0;
    GradeIt = 1'b1; tick(1); GradeIt = 1'b0; tick(3);
    check("t4_no_req", req_cycles, 0);

    // 5: credit eligibility and saturation
    do_reset();
    press(1'b1, 1'b0);
    check("t5_no_start", int'(ongoingGame), 0);
    press(1'b1, 1'b1);
    check("t5_coin_no_start", int'(ongoingGame), 0);
    check("t5_coin_credit", int'(NumGames), 1);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b1);
    check("t5_saturate", int'(NumGames), 7);
    press(1'b1, 1'b1);
    check("t5_net_zero", int'(NumGames), 7);
    check("t5_started", int'(ongoingGame), 1);

    // 6: asynchronous reset during GRADE
    do_reset();
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("t6_credits4", int'(NumGames), 4);
    load_all();
    GradeIt = 1'b1; tick(1); GradeIt = 1'b0;
    StartGame = 1'b1;
    tick(1);
    check("t6_req_high", int'(gradeReq), 1);
    check("t6_no_restart", int'(NumGames), 4);
    #2 reset = 1'b0;
    #1;
    check("t6_req_drop", int'(gradeReq), 0);
    check("t6_credits_lost", int'(NumGames), 0);
    check("t6_idle", int'(ongoingGame), 0);
    tick(2);
    reset = 1'b1;
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    tick(2);
    check("t6_held_no_start", int'(ongoingGame), 0);
    check("t6_credits2", int'(NumGames), 2);
    StartGame = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
